// File: rtl/clockmaster_pkg.sv
// Shared definitions for the clockmaster capture/generation blocks:
// FSM encoding, default tick rate and Thunderbolt time-of-day layout.
package clockmaster_pkg;

    localparam int CLKS_PER_US_DEFAULT = 10;
    localparam int YEAR_W              = 16;
    localparam int FIELD_W             = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HIGH   = 2'd1,
        ST_REPORT = 2'd2
    } ts_state_e;

    typedef struct packed {
        logic [YEAR_W-1:0]  year;
        logic [FIELD_W-1:0] month;
        logic [FIELD_W-1:0] day;
        logic [FIELD_W-1:0] hour;
        logic [FIELD_W-1:0] minutes;
        logic [FIELD_W-1:0] seconds;
    } tod_t;

endpackage

// File: rtl/us_tick_counter.sv
// Prescaled microsecond counter with saturation. A clear loads the state for
// "one cycle elapsed", so o_count always equals floor(cycles since clear / CLKS_PER_US).
module us_tick_counter #(
    parameter int CLKS_PER_US = 10,
    parameter int WIDTH       = 24
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    localparam int               PW         = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLKS_PER_US - 1);
    localparam logic [PW-1:0]    PRESC_LOAD = (CLKS_PER_US > 1) ? PW'(1) : PW'(0);
    localparam logic [WIDTH-1:0] COUNT_LOAD = (CLKS_PER_US > 1) ? WIDTH'(0) : WIDTH'(1);
    localparam logic [WIDTH-1:0] COUNT_MAX  = {WIDTH{1'b1}};

    logic [PW-1:0]    presc_r;
    logic [WIDTH-1:0] count_r;

    // Prescaler and saturating count update
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc_r <= {PW{1'b0}};
            count_r <= {WIDTH{1'b0}};
        end else if (i_clear) begin
            presc_r <= PRESC_LOAD;
            count_r <= COUNT_LOAD;
        end else if (i_enable) begin
            if (presc_r == PRESC_LAST) begin
                presc_r <= {PW{1'b0}};
                if (count_r != COUNT_MAX) begin
                    count_r <= count_r + WIDTH'(1);
                end
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end
    end

    assign o_count = count_r;

endmodule

// File: rtl/pulse_timestamper.sv
// Timestamps the rising edge of an external pulse against PPS and the Thunderbolt
// time of day, measures its high width in microseconds and holds one record for the host.
module pulse_timestamper
    import clockmaster_pkg::*;
#(
    parameter int CLKS_PER_US = CLKS_PER_US_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_capture_enable,
    input  logic        i_pulse_in,
    input  logic        i_pps_raw,
    input  logic        i_thunder_packet_dv,
    input  logic [15:0] i_thunder_year,
    input  logic [7:0]  i_thunder_month,
    input  logic [7:0]  i_thunder_day,
    input  logic [7:0]  i_thunder_hour,
    input  logic [7:0]  i_thunder_minutes,
    input  logic [7:0]  i_thunder_seconds,
    input  logic        i_ts_ack,
    input  logic        i_ovf_clr,
    output logic        o_ts_valid,
    output logic [15:0] o_ts_year,
    output logic [7:0]  o_ts_month,
    output logic [7:0]  o_ts_day,
    output logic [7:0]  o_ts_hour,
    output logic [7:0]  o_ts_minutes,
    output logic [7:0]  o_ts_seconds,
    output logic [23:0] o_ts_offset_us,
    output logic [31:0] o_ts_width_us,
    output logic        o_ts_stale,
    output logic        o_overflow
);

    logic [SYNC_STAGES-1:0] pulse_sync_r;
    logic [SYNC_STAGES-1:0] pps_sync_r;
    logic                   pulse_d_r;
    logic                   pps_d_r;
    logic                   pulse_rise_s;
    logic                   pulse_fall_s;
    logic                   pps_rise_s;
    tod_t                   shadow_r;
    logic                   fresh_r;
    ts_state_e              state_r;
    ts_state_e              next_s;
    logic                   capture_s;
    logic                   finish_s;
    logic                   drop_s;
    logic [23:0]            offset_cnt_s;
    logic [31:0]            width_cnt_s;

    // The pulse chain resets high so a pulse already high at reset release is
    // not mistaken for a fresh rising edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pulse_sync_r <= {SYNC_STAGES{1'b1}};
            pulse_d_r    <= 1'b1;
            pps_sync_r   <= {SYNC_STAGES{1'b0}};
            pps_d_r      <= 1'b0;
        end else begin
            pulse_sync_r <= {pulse_sync_r[SYNC_STAGES-2:0], i_pulse_in};
            pulse_d_r    <= pulse_sync_r[SYNC_STAGES-1];
            pps_sync_r   <= {pps_sync_r[SYNC_STAGES-2:0], i_pps_raw};
            pps_d_r      <= pps_sync_r[SYNC_STAGES-1];
        end
    end

    assign pulse_rise_s = pulse_sync_r[SYNC_STAGES-1] & ~pulse_d_r;
    assign pulse_fall_s = ~pulse_sync_r[SYNC_STAGES-1] & pulse_d_r;
    assign pps_rise_s   = pps_sync_r[SYNC_STAGES-1] & ~pps_d_r;

    // Time-of-day shadow and packet freshness; a packet beats a coincident PPS
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow_r <= '0;
            fresh_r  <= 1'b0;
        end else if (i_thunder_packet_dv) begin
            shadow_r <= '{i_thunder_year, i_thunder_month, i_thunder_day,
                          i_thunder_hour, i_thunder_minutes, i_thunder_seconds};
            fresh_r  <= 1'b1;
        end else if (pps_rise_s) begin
            fresh_r  <= 1'b0;
        end
    end

    us_tick_counter #(.CLKS_PER_US(CLKS_PER_US), .WIDTH(24)) u_offset (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (pps_rise_s),
        .i_enable (1'b1),
        .o_count  (offset_cnt_s)
    );

    us_tick_counter #(.CLKS_PER_US(CLKS_PER_US), .WIDTH(32)) u_width (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (capture_s),
        .i_enable ((state_r == ST_HIGH) & ~pulse_fall_s),
        .o_count  (width_cnt_s)
    );

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next state and capture strobes
    always_comb begin
        next_s    = state_r;
        capture_s = 1'b0;
        finish_s  = 1'b0;
        if (!i_capture_enable) begin
            next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pulse_rise_s) begin
                        next_s    = ST_HIGH;
                        capture_s = 1'b1;
                    end else begin
                        next_s = ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    if (pulse_fall_s) begin
                        next_s   = ST_REPORT;
                        finish_s = 1'b1;
                    end else begin
                        next_s = ST_HIGH;
                    end
                end
                ST_REPORT: begin
                    if (i_ts_ack) begin
                        next_s = ST_IDLE;
                    end else begin
                        next_s = ST_REPORT;
                    end
                end
                default: next_s = ST_IDLE;
            endcase
        end
    end

    assign drop_s = i_capture_enable & (state_r == ST_REPORT) & pulse_rise_s;

    // Registered record, valid flag and sticky overflow
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ts_valid     <= 1'b0;
            o_ts_year      <= 16'd0;
            o_ts_month     <= 8'd0;
            o_ts_day       <= 8'd0;
            o_ts_hour      <= 8'd0;
            o_ts_minutes   <= 8'd0;
            o_ts_seconds   <= 8'd0;
            o_ts_offset_us <= 24'd0;
            o_ts_width_us  <= 32'd0;
            o_ts_stale     <= 1'b0;
            o_overflow     <= 1'b0;
        end else begin
            o_ts_valid <= (next_s == ST_REPORT);
            if (capture_s) begin
                o_ts_year      <= shadow_r.year;
                o_ts_month     <= shadow_r.month;
                o_ts_day       <= shadow_r.day;
                o_ts_hour      <= shadow_r.hour;
                o_ts_minutes   <= shadow_r.minutes;
                o_ts_seconds   <= shadow_r.seconds;
                o_ts_offset_us <= pps_rise_s ? 24'd0 : offset_cnt_s;
                // A PPS edge in the capture cycle opens a second with no packet yet
                o_ts_stale     <= ~fresh_r | pps_rise_s;
            end
            if (finish_s) begin
                o_ts_width_us <= width_cnt_s;
            end
            if (drop_s) begin
                o_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_timestamper.sv
// Randomized scoreboard bench for pulse_timestamper: expected records come from a
// cycle-count reference model; a monitor pops and compares each presented record.
module tb_pulse_timestamper;
    import clockmaster_pkg::*;

    localparam int C  = 10;
    localparam int SS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        pulse_in = 1'b0;
    logic        pps_raw = 1'b0;
    logic        dv = 1'b0;
    tod_t        pkt = '0;
    logic        ack = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        valid;
    logic [15:0] year;
    logic [7:0]  month, day, hour, minutes, seconds;
    logic [23:0] offset_us;
    logic [31:0] width_us;
    logic        stale;
    logic        overflow;

    pulse_timestamper #(.CLKS_PER_US(C), .SYNC_STAGES(SS)) dut (
        .i_clk(clk), .i_rst(rst), .i_capture_enable(en), .i_pulse_in(pulse_in),
        .i_pps_raw(pps_raw), .i_thunder_packet_dv(dv),
        .i_thunder_year(pkt.year), .i_thunder_month(pkt.month), .i_thunder_day(pkt.day),
        .i_thunder_hour(pkt.hour), .i_thunder_minutes(pkt.minutes),
        .i_thunder_seconds(pkt.seconds), .i_ts_ack(ack), .i_ovf_clr(ovf_clr),
        .o_ts_valid(valid), .o_ts_year(year), .o_ts_month(month), .o_ts_day(day),
        .o_ts_hour(hour), .o_ts_minutes(minutes), .o_ts_seconds(seconds),
        .o_ts_offset_us(offset_us), .o_ts_width_us(width_us), .o_ts_stale(stale),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        tod_t        tod;
        int unsigned off;
        int unsigned wid;
        bit          stale;
    } rec_t;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   rec_no = 0;
    bit   auto_ack = 1'b1;
    rec_t exp_q[$];

    // reference model state, in units of input drive cycles
    int   last_pps = -1;
    int   last_pkt = -1;
    tod_t model_tod = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pps();
        pps_raw  = 1'b1;
        last_pps = cyc;
        step(3);
        pps_raw  = 1'b0;
    endtask

    task automatic send_pkt(input tod_t t);
        pkt       = t;
        dv        = 1'b1;
        last_pkt  = cyc;
        model_tod = t;
        step(1);
        dv = 1'b0;
    endtask

    task automatic do_pulse(input int len, input bit with_pps, input bit expect_rec, output rec_t r);
        int rise;
        longint off;
        pulse_in = 1'b1;
        rise     = cyc;
        if (with_pps) begin
            pps_raw  = 1'b1;
            last_pps = cyc;
        end
        off     = longint'(rise - last_pps) / C;
        r.tod   = model_tod;
        r.off   = (off > 64'd16777215) ? 32'd16777215 : int'(off);
        r.stale = !(last_pkt > last_pps);
        r.wid   = len / C;
        for (int i = 0; i < len; i++) begin
            step(1);
            if (i == 2) pps_raw = 1'b0;
        end
        pulse_in = 1'b0;
        pps_raw  = 1'b0;
        if (expect_rec) exp_q.push_back(r);
    endtask

    task automatic rand_pkt();
        tod_t t;
        t.year    = 16'($urandom_range(2000, 2099));
        t.month   = 8'($urandom_range(1, 12));
        t.day     = 8'($urandom_range(1, 28));
        t.hour    = 8'($urandom_range(0, 23));
        t.minutes = 8'($urandom_range(0, 59));
        t.seconds = 8'($urandom_range(0, 59));
        send_pkt(t);
    endtask

    // monitor: compare each new record once, and play the host acknowledging it
    initial begin
        bit   seen;
        rec_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
                ack  = 1'b0;
            end else begin
                if (valid && !seen) begin
                    seen = 1'b1;
                    rec_no++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL record%0d: unexpected record off=%0d wid=%0d", rec_no, offset_us, width_us);
                    end else begin
                        e = exp_q.pop_front();
                        if ({year, month, day, hour, minutes, seconds} !== e.tod ||
                            offset_us !== 24'(e.off) || width_us !== e.wid || stale !== e.stale) begin
                            errors++;
                            $display("FAIL record%0d: got %0d-%0d-%0d %0d:%0d:%0d off=%0d wid=%0d stale=%0b, expected %0d-%0d-%0d %0d:%0d:%0d off=%0d wid=%0d stale=%0b",
                                     rec_no, year, month, day, hour, minutes, seconds, offset_us, width_us, stale,
                                     e.tod.year, e.tod.month, e.tod.day, e.tod.hour, e.tod.minutes, e.tod.seconds,
                                     e.off, e.wid, e.stale);
                        end
                    end
                end
                if (!valid) seen = 1'b0;
                if (ack) ack = 1'b0;
                else if (valid && auto_ack) ack = 1'b1;
            end
        end
    end

    initial begin
        rec_t r;
        rec_t held;
        tod_t t;
        int   t0;

        step(3);
        chk("reset_outputs", {valid, year, month, day, hour, minutes, seconds, stale, overflow}, 64'd0);
        chk("reset_offset_width", {offset_us, width_us}, 64'd0);
        rst = 1'b0;
        step(5);

        // reference capture: 2024-03-15 12:34:56, offset 1234, width 100
        pps();
        t0 = last_pps;
        step(47);
        t = '{16'd2024, 8'd3, 8'd15, 8'd12, 8'd34, 8'd56};
        send_pkt(t);
        step(t0 + 12345 - cyc);
        do_pulse(1000, 1'b0, 1'b1, r);
        step(20);
        do_pulse(25, 1'b0, 1'b1, r);
        step(20);
        do_pulse(9, 1'b0, 1'b1, r);
        step(20);
        // rise coincident with PPS: offset 0, stale, previous time
        do_pulse(30, 1'b1, 1'b1, r);
        step(20);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pps();
                step($urandom_range(10, 40));
            end
            if ($urandom_range(0, 2) == 0) begin
                rand_pkt();
                step($urandom_range(10, 40));
            end
            do_pulse($urandom_range(1, 300), 1'b0, 1'b1, r);
            step($urandom_range(12, 40));
        end

        // second pulse while the first record is still held
        auto_ack = 1'b0;
        do_pulse(50, 1'b0, 1'b1, held);
        step(15);
        do_pulse(30, 1'b0, 1'b0, r);
        step(10);
        chk("overflow_set", overflow, 1);
        chk("held_valid", valid, 1);
        chk("held_offset", offset_us, held.off);
        chk("held_width", width_us, held.wid);
        auto_ack = 1'b1;
        step(10);
        chk("valid_after_ack", valid, 0);
        chk("overflow_sticky", overflow, 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        step(1);
        chk("overflow_clr", overflow, 0);
        do_pulse(40, 1'b0, 1'b1, r);
        step(20);

        // enable dropped in REPORT, then while HIGH
        auto_ack = 1'b0;
        do_pulse(20, 1'b0, 1'b1, r);
        step(10);
        chk("valid_in_report", valid, 1);
        en = 1'b0;
        step(2);
        chk("valid_enable_low", valid, 0);
        en = 1'b1;
        auto_ack = 1'b1;
        step(5);
        pulse_in = 1'b1;
        step(20);
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(10);
        pulse_in = 1'b0;
        step(20);
        chk("no_record_after_enable_drop", valid, 0);
        do_pulse(35, 1'b0, 1'b1, r);
        step(20);

        // asynchronous reset mid-pulse, released while the pulse is still high
        pulse_in = 1'b1;
        step(30);
        rst = 1'b1;
        step(2);
        chk("valid_in_reset", valid, 0);
        rst = 1'b0;
        model_tod = '0;
        last_pkt  = -1;
        step(10);
        pulse_in = 1'b0;
        step(20);
        chk("no_record_after_reset", valid, 0);
        chk("overflow_after_reset", overflow, 0);
        pps();
        step(20);
        do_pulse(60, 1'b0, 1'b1, r);
        step(20);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
